// File: rtl/if_icache.sv
// Instruction-fetch front end with a direct-mapped, one-word-per-line instruction cache.
// Misses are filled through the byte-serial memory controller's instruction port.
module if_icache #(
    parameter int unsigned INDEX_W = 7,
    parameter int unsigned TAG_W   = 23
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_en_i,
    input  logic [31:0] pc_i,
    input  logic        stall_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
    output logic        mem_inst_req_o,
    output logic [31:0] mem_inst_addr_o,
    input  logic [31:0] mem_inst_i,
    input  logic [31:0] mem_inst_pc_i,
    input  logic        mem_inst_done_i
);
    localparam int unsigned Lines = 1 << INDEX_W;

    typedef enum logic [0:0] {StIdle, StMiss} state_e;

    state_e state_q, state_d;

    logic [Lines-1:0] valid_q;
    logic [TAG_W-1:0] tag_q  [Lines];
    logic [31:0]      data_q [Lines];

    logic        inst_valid_q, inst_valid_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] pc_q, pc_d;
    logic        req_q, req_d;
    logic [31:0] addr_q, addr_d;

    logic [INDEX_W-1:0] idx, fill_idx;
    logic [TAG_W-1:0]   pc_tag, fill_tag;
    logic               hit, fill_we;

    assign idx      = pc_i[INDEX_W+1:2];
    assign pc_tag   = pc_i[31:INDEX_W+2];
    assign fill_idx = mem_inst_pc_i[INDEX_W+1:2];
    assign fill_tag = mem_inst_pc_i[31:INDEX_W+2];
    assign hit      = valid_q[idx] && (tag_q[idx] == pc_tag);

    always_comb begin
        state_d      = state_q;
        inst_valid_d = inst_valid_q;
        inst_d       = inst_q;
        pc_d         = pc_q;
        req_d        = req_q;
        addr_d       = addr_q;
        fill_we      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!stall_i) begin
                    if (fetch_en_i && hit) begin
                        inst_valid_d = 1'b1;
                        inst_d       = data_q[idx];
                        pc_d         = pc_i;
                    end else if (fetch_en_i) begin
                        inst_valid_d = 1'b0;
                        req_d        = 1'b1;
                        addr_d       = pc_i;
                        state_d      = StMiss;
                    end else begin
                        inst_valid_d = 1'b0;
                    end
                end
            end
            StMiss: begin
                if (!stall_i) inst_valid_d = 1'b0;
                if (mem_inst_done_i) begin
                    // Drop req on the done edge so the controller does not restart from Vacant.
                    fill_we = 1'b1;
                    req_d   = 1'b0;
                    state_d = StIdle;
                    if (!stall_i && fetch_en_i && (mem_inst_pc_i == pc_i)) begin
                        inst_valid_d = 1'b1;
                        inst_d       = mem_inst_i;
                        pc_d         = pc_i;
                    end
                end else if (fetch_en_i && (pc_i != addr_q)) begin
                    addr_d = pc_i;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            valid_q      <= '0;
            inst_valid_q <= 1'b0;
            inst_q       <= '0;
            pc_q         <= '0;
            req_q        <= 1'b0;
            addr_q       <= '0;
        end else begin
            state_q      <= state_d;
            inst_valid_q <= inst_valid_d;
            inst_q       <= inst_d;
            pc_q         <= pc_d;
            req_q        <= req_d;
            addr_q       <= addr_d;
            if (fill_we) valid_q[fill_idx] <= 1'b1;
        end
    end

    // Tag and data storage carry no reset; the valid bits gate their use.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            data_q[fill_idx] <= mem_inst_i;
            tag_q[fill_idx]  <= fill_tag;
        end
    end

    assign inst_valid_o    = inst_valid_q;
    assign inst_o          = inst_q;
    assign pc_o            = pc_q;
    assign mem_inst_req_o  = req_q;
    assign mem_inst_addr_o = addr_q;

endmodule

// File: tb/tb_if_icache.sv
// Directed bench for if_icache: the memory controller is played by hand-driven done pulses.
module tb_if_icache;
    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_en_i;
    logic [31:0] pc_i;
    logic        stall_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] pc_o;
    logic        mem_inst_req_o;
    logic [31:0] mem_inst_addr_o;
    logic [31:0] mem_inst_i;
    logic [31:0] mem_inst_pc_i;
    logic        mem_inst_done_i;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] W0   = 32'h0040_0093;
    localparam logic [31:0] W4   = 32'h0010_8113;
    localparam logic [31:0] W8   = 32'h0021_0193;
    localparam logic [31:0] W200 = 32'hDEAD_BEEF;
    localparam logic [31:0] W80  = 32'h1234_5678;

    if_icache dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_en_i     (fetch_en_i),
        .pc_i           (pc_i),
        .stall_i        (stall_i),
        .inst_valid_o   (inst_valid_o),
        .inst_o         (inst_o),
        .pc_o           (pc_o),
        .mem_inst_req_o (mem_inst_req_o),
        .mem_inst_addr_o(mem_inst_addr_o),
        .mem_inst_i     (mem_inst_i),
        .mem_inst_pc_i  (mem_inst_pc_i),
        .mem_inst_done_i(mem_inst_done_i)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic done_pulse(input logic [31:0] pc, input logic [31:0] word);
        mem_inst_pc_i   = pc;
        mem_inst_i      = word;
        mem_inst_done_i = 1'b1;
        tick();
        mem_inst_done_i = 1'b0;
    endtask

    // Full miss-then-fill of one address, checking request and bypass output.
    task automatic fill(input string tag, input logic [31:0] pc, input logic [31:0] word);
        pc_i       = pc;
        fetch_en_i = 1'b1;
        tick();
        chk({tag, "_req"}, {31'b0, mem_inst_req_o}, 32'd1);
        chk({tag, "_addr"}, mem_inst_addr_o, pc);
        chk({tag, "_vmiss"}, {31'b0, inst_valid_o}, 32'd0);
        tick();
        done_pulse(pc, word);
        chk({tag, "_valid"}, {31'b0, inst_valid_o}, 32'd1);
        chk({tag, "_inst"}, inst_o, word);
        chk({tag, "_pc"}, pc_o, pc);
        chk({tag, "_reqdrop"}, {31'b0, mem_inst_req_o}, 32'd0);
    endtask

    task automatic chk_hit(input string tag, input logic [31:0] pc, input logic [31:0] word);
        chk({tag, "_valid"}, {31'b0, inst_valid_o}, 32'd1);
        chk({tag, "_inst"}, inst_o, word);
        chk({tag, "_pc"}, pc_o, pc);
        chk({tag, "_req"}, {31'b0, mem_inst_req_o}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; fetch_en_i = 1'b0; pc_i = '0; stall_i = 1'b0;
        mem_inst_i = '0; mem_inst_pc_i = '0; mem_inst_done_i = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_valid", {31'b0, inst_valid_o}, 32'd0);
        chk("rst_inst", inst_o, 32'd0);
        chk("rst_pc", pc_o, 32'd0);
        chk("rst_req", {31'b0, mem_inst_req_o}, 32'd0);
        chk("rst_addr", mem_inst_addr_o, 32'd0);

        // Cold miss with the controller taking a few cycles.
        pc_i = 32'h0; fetch_en_i = 1'b1;
        tick();
        chk("cold_req", {31'b0, mem_inst_req_o}, 32'd1);
        chk("cold_addr", mem_inst_addr_o, 32'h0);
        tick(); tick(); tick();
        chk("cold_reqhold", {31'b0, mem_inst_req_o}, 32'd1);
        chk("cold_vwait", {31'b0, inst_valid_o}, 32'd0);
        done_pulse(32'h0, W0);
        chk("cold_valid", {31'b0, inst_valid_o}, 32'd1);
        chk("cold_inst", inst_o, W0);
        chk("cold_pc", pc_o, 32'h0);
        chk("cold_reqdrop", {31'b0, mem_inst_req_o}, 32'd0);

        tick();
        chk_hit("hit0", 32'h0, W0);

        fill("fill4", 32'h4, W4);
        fill("fill8", 32'h8, W8);

        // Back-to-back hits, one per cycle.
        pc_i = 32'h0; tick(); chk_hit("b2b0", 32'h0, W0);
        pc_i = 32'h4; tick(); chk_hit("b2b4", 32'h4, W4);
        pc_i = 32'h8; tick(); chk_hit("b2b8", 32'h8, W8);

        // Stall holds outputs while pc_i moves on.
        pc_i = 32'h4; tick(); chk_hit("pre_stall", 32'h4, W4);
        stall_i = 1'b1; pc_i = 32'h8;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_valid", {31'b0, inst_valid_o}, 32'd1);
            chk("stall_inst", inst_o, W4);
            chk("stall_pc", pc_o, 32'h4);
        end
        stall_i = 1'b0;
        tick();
        chk_hit("post_stall", 32'h8, W8);

        // Conflict: 0x200 shares index 0 and evicts 0x0.
        fill("conf200", 32'h200, W200);
        pc_i = 32'h0;
        tick();
        chk("evict_req", {31'b0, mem_inst_req_o}, 32'd1);
        chk("evict_addr", mem_inst_addr_o, 32'h0);
        chk("evict_valid", {31'b0, inst_valid_o}, 32'd0);
        done_pulse(32'h0, W0);
        chk("evict_inst", inst_o, W0);

        // Redirect mid-miss.
        pc_i = 32'h10;
        tick();
        chk("redir_addr0", mem_inst_addr_o, 32'h10);
        tick();
        chk("redir_v1", {31'b0, inst_valid_o}, 32'd0);
        pc_i = 32'h80;
        tick();
        chk("redir_addr1", mem_inst_addr_o, 32'h80);
        chk("redir_req", {31'b0, mem_inst_req_o}, 32'd1);
        chk("redir_v2", {31'b0, inst_valid_o}, 32'd0);
        done_pulse(32'h80, W80);
        chk("redir_valid", {31'b0, inst_valid_o}, 32'd1);
        chk("redir_pc", pc_o, 32'h80);
        chk("redir_inst", inst_o, W80);

        // Reset during a miss; a late done pulse must not fill.
        pc_i = 32'h20;
        tick();
        chk("rmiss_req", {31'b0, mem_inst_req_o}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0; fetch_en_i = 1'b0;
        chk("rmiss_valid", {31'b0, inst_valid_o}, 32'd0);
        chk("rmiss_inst", inst_o, 32'd0);
        chk("rmiss_pc", pc_o, 32'd0);
        chk("rmiss_reqz", {31'b0, mem_inst_req_o}, 32'd0);
        chk("rmiss_addr", mem_inst_addr_o, 32'd0);
        done_pulse(32'h20, 32'hCAFE_F00D);
        chk("spur_req", {31'b0, mem_inst_req_o}, 32'd0);
        chk("spur_valid", {31'b0, inst_valid_o}, 32'd0);
        fetch_en_i = 1'b1;
        tick();
        chk("remiss_req", {31'b0, mem_inst_req_o}, 32'd1);
        chk("remiss_addr", mem_inst_addr_o, 32'h20);
        chk("remiss_valid", {31'b0, inst_valid_o}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/if_icache.md
Name: if_icache

Overview:
Instruction-fetch front end with a direct-mapped instruction cache. It sits between the PC register and the memory controller's instruction port. It drives the controller's inst_req/inst_addr_i inputs and consumes inst_o/inst_pc/inst_done_o. Decoded-stage consumers receive one word-aligned 32-bit instruction per hit cycle; misses are filled through the byte-serial memory controller.

Parameters:
INDEX_W, 7, index bits; the cache holds 2^INDEX_W one-word lines (128).
TAG_W, 23, tag bits, equal to 30 - INDEX_W; tag = pc[31 : INDEX_W+2].

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
fetch_en_i  input  1  pipeline requests an instruction at pc_i
pc_i  input  32  fetch address, word-aligned (pc_i[1:0] = 0)
stall_i  input  1  downstream stall; freezes the output registers
inst_valid_o  output  1  inst_o/pc_o hold a valid instruction this cycle
inst_o  output  32  fetched instruction
pc_o  output  32  address of inst_o
mem_inst_req_o  output  1  to memory controller inst_req
mem_inst_addr_o  output  32  to memory controller inst_addr_i
mem_inst_i  input  32  from memory controller inst_o
mem_inst_pc_i  input  32  from memory controller inst_pc
mem_inst_done_i  input  1  from memory controller inst_done_o (1-cycle pulse)

Behaviour:
- Reset (rst high at a posedge): all valid bits cleared; inst_valid_o=0, inst_o=0, pc_o=0, mem_inst_req_o=0, mem_inst_addr_o=0; state=IDLE. Reset overrides an in-flight miss; a later done pulse for that miss is ignored (state is IDLE, req low).
- Lookup is combinational: idx=pc_i[INDEX_W+1:2], hit = valid[idx] && tag[idx]==pc_i[31:INDEX_W+2]. The tag and data arrays are plain registers with no reset on data/tag.
- Precedence each posedge after reset: stall_i, then the state action.
- stall_i=1: inst_o, pc_o, and inst_valid_o hold. No new lookup is started. A miss in flight continues, and a fill still writes the array.
- IDLE, fetch_en_i=1, hit: at the next edge inst_o=data[idx], pc_o=pc_i, inst_valid_o=1. Hit latency is 1 cycle, with back-to-back hits at 1 per cycle.
- IDLE, fetch_en_i=1, miss: inst_valid_o<=0, mem_inst_req_o<=1, mem_inst_addr_o<=pc_i, state<=MISS.
- IDLE, fetch_en_i=0: inst_valid_o<=0.
- MISS, every cycle: inst_valid_o<=0.
- MISS, mem_inst_done_i=1: write data[mem_inst_pc_i idx]=mem_inst_i, set its tag, and set valid=1. Always drop mem_inst_req_o<=0 that same edge, so the controller does not restart a fetch from Vacant.
  - If mem_inst_pc_i==pc_i and fetch_en_i=1: inst_o=mem_inst_i, pc_o=pc_i, inst_valid_o=1 (bypass, no extra lookup cycle); state<=IDLE.
  - Otherwise (stale fill after redirect): state<=IDLE with no output; the next IDLE cycle re-looks-up pc_i.
- MISS, no done, pc_i != mem_inst_addr_o (branch redirect): mem_inst_addr_o<=pc_i and req stays 1. The controller restarts on the address change. If the new pc_i now hits, still wait for done (the controller is mid-transaction), then re-lookup.
- MISS, no done, fetch_en_i=0: keep req; complete the fill, do not output, then return to IDLE.
- Miss latency: req rises at edge t+1. The controller reads 4 bytes plus assembly; done arrives roughly 6 cycles after it accepts the request, longer if data-port traffic has priority. Output appears at the done edge.
- Done pulse while in IDLE (spurious): ignored, no array write.
- Addresses: index/tag slicing only; no arithmetic. pc_i[1:0] is ignored.

Test Plan:
- Cold miss: reset, fetch_en_i=1, pc_i=0x0000_0000, memory word 0x0040_0093 → req=1 with addr 0x0 the cycle after; on done, inst_o=0x0040_0093, pc_o=0x0, inst_valid_o=1 at the done edge; req=0 the same edge.
- Hit after fill: pc_i=0x0 again → inst_valid_o=1, inst_o=0x0040_0093 one cycle later, and req stays 0. Then pc 0x4 (hit), 0x8 (hit) on consecutive cycles → valid in 3 consecutive cycles.
- Conflict eviction: fill 0x0000_0000, then 0x0000_0200 (same idx 0, INDEX_W=7) → second is a miss; re-fetch 0x0 → miss again, with req asserted and addr 0x0.
- Redirect mid-miss: miss on 0x10, and 2 cycles later pc_i=0x80 → mem_inst_addr_o=0x80 next cycle. Done with inst_pc=0x80 → output pc_o=0x80. No output is produced for 0x10.
- Stall hold: hit produces inst_o=X at pc 0x4, then stall_i=1 for 3 cycles with pc_i changed to 0x8 → inst_o, pc_o=0x4, and inst_valid_o=1 are unchanged until stall_i drops.
- Reset mid-miss: assert rst during MISS → all outputs 0 next edge; a subsequent done pulse writes nothing. A fetch of the same pc misses again.
